// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the RC pulse meter
//
// Purpose: value width, FSM state type and default timing limits shared by
//          rc_pulse_meter and its testbench.
// Ports:   none (package).
package pwm_pkg;

    localparam int PWM_W = 16;

    localparam int DEF_MIN_US     = 800;
    localparam int DEF_MAX_US     = 2200;
    localparam int DEF_TIMEOUT_US = 25000;

    typedef enum logic [1:0] {
        ST_WAIT_LOW  = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_glitch_filter.sv
// rtl/pwm_glitch_filter.sv - input synchronizer and optional glitch filter
//
// Purpose: brings the asynchronous PWM pin into the clock domain through two
//          flops and, when RC_PULSE_METER_FILTER_EN is defined, only accepts a
//          level change after FILTER_LEN consecutive equal samples.
// Config:  RC_PULSE_METER_FILTER_EN defined   -> latency 2+FILTER_LEN cycles
//          RC_PULSE_METER_FILTER_EN undefined -> latency 2 cycles
// Ports:   i_clk    - clock, rising edge
//          i_resetn - asynchronous active-low reset
//          i_pwm    - raw PWM pin
//          o_level  - filtered level
module pwm_glitch_filter
`ifdef RC_PULSE_METER_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_pwm,
    output logic o_level
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_pwm};
        end
    end

`ifdef RC_PULSE_METER_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_level;

    // r_cnt counts consecutive samples that disagree with the held level;
    // any agreeing sample restarts the run.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;
`else
    assign o_level = r_sync[1];
`endif

endmodule

// File: rtl/rc_pulse_meter.sv
// rtl/rc_pulse_meter.sv - RC servo PWM high-time meter with range and timeout
//
// Purpose: measures the high time of an RC PWM signal in microseconds,
//          reports accepted widths, flags out-of-range pulses and declares
//          the signal lost after TIMEOUT_US without a valid pulse.
// Config:  RC_PULSE_METER_FILTER_EN enables the glitch filter.
// Ports:   i_clk         - clock, rising edge
//          i_resetn      - asynchronous active-low reset
//          i_pwm         - raw PWM pin, asynchronous
//          o_pwm_value   - last accepted width in us (0 after timeout)
//          o_pwm_ready   - 1-cycle strobe on every o_pwm_value update
//          o_range_err   - 1-cycle strobe for an out-of-range pulse
//          o_signal_lost - level, high while timed out
module rc_pulse_meter
    import pwm_pkg::*;
#(
    parameter int clockFreq  = 100_000_000,
    parameter int MIN_US     = DEF_MIN_US,
    parameter int MAX_US     = DEF_MAX_US,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int FILTER_LEN = 4
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_pwm,
    output logic [PWM_W-1:0] o_pwm_value,
    output logic             o_pwm_ready,
    output logic             o_range_err,
    output logic             o_signal_lost
);

    localparam int               DIV        = clockFreq / 1_000_000;
    localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    L_DIV_LAST = PW'(DIV - 1);
    localparam logic [PWM_W-1:0] L_MIN      = PWM_W'(MIN_US);
    localparam logic [PWM_W-1:0] L_MAX      = PWM_W'(MAX_US);
    localparam logic [PWM_W-1:0] L_TO_LAST  = PWM_W'(TIMEOUT_US - 1);
    localparam logic [PWM_W-1:0] L_SAT      = {PWM_W{1'b1}};
    // Cycles after reset before the filtered level is trusted to reflect the pin.
    localparam logic [7:0]       L_SETTLE   = 8'(FILTER_LEN + 4);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             w_level;
    logic             r_level_d;
    logic             w_rise;
    logic             w_fall;
    logic [PW-1:0]    r_presc;
    logic             w_tick;
    logic [7:0]       r_settle;
    logic             w_settled;
    pwm_state_t       r_state;
    pwm_state_t       w_next;
    logic [PWM_W-1:0] r_width;
    logic [PWM_W-1:0] w_width_inc;
    logic [PWM_W-1:0] w_width_fin;
    logic [PWM_W-1:0] r_timeout;
    logic             w_to_hit;
    logic             w_fall_ok;
    logic             w_fall_bad;
    logic [PWM_W-1:0] r_value;
    logic             r_ready;
    logic             r_range_err;
    logic             r_lost;

    // Reset asserts asynchronously but releases two clocks later.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef RC_PULSE_METER_FILTER_EN
    pwm_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
`else
    pwm_glitch_filter u_filter (
`endif
        .i_clk    (i_clk),
        .i_resetn (w_rst_n),
        .i_pwm    (i_pwm),
        .o_level  (w_level)
    );

    assign w_rise      = w_level & ~r_level_d;
    assign w_fall      = ~w_level & r_level_d;
    assign w_tick      = (r_presc == L_DIV_LAST);
    assign w_settled   = (r_settle == L_SETTLE);
    assign w_width_inc = (r_width == L_SAT) ? r_width : r_width + 1'b1;
    // A tick landing on the falling-edge cycle still belongs to the pulse.
    assign w_width_fin = w_tick ? w_width_inc : r_width;
    assign w_to_hit    = w_tick && (r_timeout == L_TO_LAST);

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_level_d <= 1'b0;
            r_presc   <= '0;
            r_settle  <= '0;
            r_state   <= ST_WAIT_LOW;
        end else begin
            r_level_d <= w_level;
            r_state   <= w_next;
            if (!w_settled) begin
                r_settle <= r_settle + 1'b1;
            end
            // Restarting on the rising edge aligns the us grid to the pulse.
            if (w_rise || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_fall_ok  = 1'b0;
        w_fall_bad = 1'b0;
        case (r_state)
            ST_WAIT_LOW: begin
                if (w_settled && !w_level) begin
                    w_next = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (w_rise) begin
                    w_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_fall) begin
                    w_next = ST_WAIT_RISE;
                    if (w_width_fin >= L_MIN && w_width_fin <= L_MAX) begin
                        w_fall_ok = 1'b1;
                    end else begin
                        w_fall_bad = 1'b1;
                    end
                end
            end
            default: w_next = ST_WAIT_LOW;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_width     <= '0;
            r_timeout   <= '0;
            r_value     <= '0;
            r_ready     <= 1'b0;
            r_range_err <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_RISE && w_rise) begin
                r_width <= '0;
            end else if (r_state == ST_MEASURE && w_tick) begin
                r_width <= w_width_inc;
            end

            if (w_fall_ok) begin
                r_timeout <= '0;
            end else if (w_tick && r_timeout != L_SAT) begin
                r_timeout <= r_timeout + 1'b1;
            end

            r_ready <= w_fall_ok || w_to_hit;
            // The timeout strobe takes precedence so both never coincide.
            r_range_err <= w_fall_bad && !w_to_hit;

            if (w_fall_ok) begin
                r_value <= w_width_fin;
                r_lost  <= 1'b0;
            end else if (w_to_hit) begin
                r_value <= '0;
                r_lost  <= 1'b1;
            end
        end
    end

    assign o_pwm_value   = r_value;
    assign o_pwm_ready   = r_ready;
    assign o_range_err   = r_range_err;
    assign o_signal_lost = r_lost;

endmodule

// File: tb/tb_rc_pulse_meter.sv
// tb/tb_rc_pulse_meter.sv - self-checking bench for rc_pulse_meter
module tb_rc_pulse_meter;

    localparam int CPU    = 4;     // clock cycles per microsecond
    localparam int MIN_US = 80;
    localparam int MAX_US = 220;
    localparam int TO_US  = 2500;

    logic        clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_pwm = 1'b0;
    logic [15:0] o_pwm_value;
    logic        o_pwm_ready;
    logic        o_range_err;
    logic        o_signal_lost;

    int checks = 0;
    int failures = 0;

    int          n_ready = 0;
    int          n_range = 0;
    int          n_both = 0;
    int          n_long = 0;
    logic [15:0] last_val = '0;
    logic        prev_r = 1'b0;
    logic        prev_e = 1'b0;
    int          m_val = 0;        // model: last accepted width in us

    always #5 clk = ~clk;

    rc_pulse_meter #(
        .clockFreq  (CPU * 1_000_000),
        .MIN_US     (MIN_US),
        .MAX_US     (MAX_US),
        .TIMEOUT_US (TO_US),
        .FILTER_LEN (4)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (i_resetn),
        .i_pwm         (i_pwm),
        .o_pwm_value   (o_pwm_value),
        .o_pwm_ready   (o_pwm_ready),
        .o_range_err   (o_range_err),
        .o_signal_lost (o_signal_lost)
    );

    always @(negedge clk) begin
        if (o_pwm_ready) begin
            n_ready++;
            last_val = o_pwm_value;
        end
        if (o_range_err) n_range++;
        if (o_pwm_ready && o_range_err) n_both++;
        if ((o_pwm_ready && prev_r) || (o_range_err && prev_e)) n_long++;
        prev_r = o_pwm_ready;
        prev_e = o_range_err;
    end

    task automatic drive(input logic lvl, input int us);
        i_pwm = lvl;
        repeat (us * CPU) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        i_resetn = 1'b0;
        i_pwm = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (o_pwm_value !== 16'd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", o_pwm_value); end
        checks++; if (o_pwm_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_pwm_ready); end
        checks++; if (o_range_err !== 1'b0) begin failures++; $display("FAIL reset_range got=%b exp=0", o_range_err); end
        checks++; if (o_signal_lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", o_signal_lost); end
        i_resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_valid;
        int r0, e0;
        r0 = n_ready; e0 = n_range;
        drive(1'b1, 150);
        drive(1'b0, 50);
        m_val = 150;
        checks++; if (n_ready - r0 != 1) begin failures++; $display("FAIL valid_ready got=%0d exp=1", n_ready - r0); end
        checks++; if (n_range - e0 != 0) begin failures++; $display("FAIL valid_range got=%0d exp=0", n_range - e0); end
        checks++; if (int'(last_val) > m_val + 1 || int'(last_val) + 1 < m_val) begin failures++; $display("FAIL valid_value got=%0d exp=%0d+/-1", last_val, m_val); end
    endtask

    task automatic test_glitch;
        int r0, e0;
        r0 = n_ready; e0 = n_range;
        drive(1'b1, 75);
        i_pwm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_pwm = 1'b1;
        repeat (75 * CPU - 3) @(posedge clk);
        #1;
        drive(1'b0, 50);
`ifdef RC_PULSE_METER_FILTER_EN
        m_val = 150;
        checks++; if (n_ready - r0 != 1 || n_range != e0) begin failures++; $display("FAIL glitch_strobes ready=%0d range=%0d exp=1,0", n_ready - r0, n_range - e0); end
        checks++; if (int'(last_val) > m_val + 1 || int'(last_val) + 1 < m_val) begin failures++; $display("FAIL glitch_value got=%0d exp=%0d+/-1", last_val, m_val); end
`else
        checks++; if (n_ready != r0 || n_range - e0 < 1) begin failures++; $display("FAIL glitch_strobes ready=%0d range=%0d exp=0,>=1", n_ready - r0, n_range - e0); end
        checks++; if (int'(o_pwm_value) > m_val + 1 || int'(o_pwm_value) + 1 < m_val) begin failures++; $display("FAIL glitch_held got=%0d exp=%0d+/-1", o_pwm_value, m_val); end
`endif
    endtask

    task automatic test_range;
        int r0, e0;
        r0 = n_ready; e0 = n_range;
        drive(1'b1, 70);
        drive(1'b0, 50);
        drive(1'b1, 250);
        drive(1'b0, 50);
        checks++; if (n_range - e0 != 2) begin failures++; $display("FAIL range_errs got=%0d exp=2", n_range - e0); end
        checks++; if (n_ready != r0) begin failures++; $display("FAIL range_ready got=%0d exp=0", n_ready - r0); end
        checks++; if (int'(o_pwm_value) > m_val + 1 || int'(o_pwm_value) + 1 < m_val) begin failures++; $display("FAIL range_held got=%0d exp=%0d+/-1", o_pwm_value, m_val); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            int w, lo, r0, e0;
            bit ok;
            w = $urandom_range(60, 240);
            while ((w >= MIN_US - 1 && w <= MIN_US + 1) || (w >= MAX_US - 1 && w <= MAX_US + 1))
                w = $urandom_range(60, 240);
            lo = $urandom_range(20, 40);
            r0 = n_ready; e0 = n_range;
            drive(1'b1, w);
            drive(1'b0, lo);
            ok = (w >= MIN_US && w <= MAX_US);
            if (ok) m_val = w;
            checks++; if (n_ready - r0 != (ok ? 1 : 0) || n_range - e0 != (ok ? 0 : 1)) begin failures++; $display("FAIL rand_strobes w=%0d ready=%0d range=%0d", w, n_ready - r0, n_range - e0); end
            checks++; if (int'(o_pwm_value) > m_val + 1 || int'(o_pwm_value) + 1 < m_val) begin failures++; $display("FAIL rand_value w=%0d got=%0d exp=%0d+/-1", w, o_pwm_value, m_val); end
        end
    endtask

    task automatic test_timeout;
        int r0;
        drive(1'b1, 100);
        r0 = n_ready;
        drive(1'b0, TO_US - 100);
        checks++; if (o_signal_lost !== 1'b0) begin failures++; $display("FAIL to_early_lost got=%b exp=0", o_signal_lost); end
        drive(1'b0, 200);
        checks++; if (o_signal_lost !== 1'b1) begin failures++; $display("FAIL to_lost got=%b exp=1", o_signal_lost); end
        checks++; if (o_pwm_value !== 16'd0) begin failures++; $display("FAIL to_value got=%0d exp=0", o_pwm_value); end
        checks++; if (n_ready - r0 != 2) begin failures++; $display("FAIL to_ready got=%0d exp=2", n_ready - r0); end
        drive(1'b0, 400);
        drive(1'b1, 120);
        drive(1'b0, 40);
        m_val = 120;
        checks++; if (o_signal_lost !== 1'b0) begin failures++; $display("FAIL to_recover_lost got=%b exp=0", o_signal_lost); end
        checks++; if (int'(o_pwm_value) > m_val + 1 || int'(o_pwm_value) + 1 < m_val) begin failures++; $display("FAIL to_recover_value got=%0d exp=%0d+/-1", o_pwm_value, m_val); end
    endtask

    task automatic test_release_high;
        int r0, e0;
        i_resetn = 1'b0;
        i_pwm = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        i_resetn = 1'b1;
        r0 = n_ready; e0 = n_range;
        drive(1'b1, 60);
        drive(1'b0, 40);
        checks++; if (n_ready != r0 || n_range != e0) begin failures++; $display("FAIL rel_partial ready=%0d range=%0d exp=0,0", n_ready - r0, n_range - e0); end
        drive(1'b1, 180);
        drive(1'b0, 40);
        m_val = 180;
        checks++; if (n_ready - r0 != 1 || n_range != e0) begin failures++; $display("FAIL rel_strobes ready=%0d range=%0d exp=1,0", n_ready - r0, n_range - e0); end
        checks++; if (int'(last_val) > m_val + 1 || int'(last_val) + 1 < m_val) begin failures++; $display("FAIL rel_value got=%0d exp=%0d+/-1", last_val, m_val); end
    endtask

    task automatic test_reset_mid_pulse;
        int r0, e0;
        drive(1'b1, 50);
        i_resetn = 1'b0;
        #1;
        checks++; if (o_pwm_value !== 16'd0 || o_signal_lost !== 1'b0) begin failures++; $display("FAIL mid_outputs value=%0d lost=%b exp=0,0", o_pwm_value, o_signal_lost); end
        checks++; if (o_pwm_ready !== 1'b0 || o_range_err !== 1'b0) begin failures++; $display("FAIL mid_strobes ready=%b range=%b exp=0,0", o_pwm_ready, o_range_err); end
        m_val = 0;
        repeat (10) @(posedge clk);
        #1;
        i_pwm = 1'b0;
        i_resetn = 1'b1;
        r0 = n_ready; e0 = n_range;
        drive(1'b0, 100);
        checks++; if (n_ready != r0 || n_range != e0) begin failures++; $display("FAIL mid_quiet ready=%0d range=%0d exp=0,0", n_ready - r0, n_range - e0); end
        drive(1'b1, 120);
        drive(1'b0, 40);
        m_val = 120;
        checks++; if (n_ready - r0 != 1) begin failures++; $display("FAIL mid_ready got=%0d exp=1", n_ready - r0); end
        checks++; if (int'(last_val) > m_val + 1 || int'(last_val) + 1 < m_val) begin failures++; $display("FAIL mid_value got=%0d exp=%0d+/-1", last_val, m_val); end
    endtask

    task automatic test_strobe_shape;
        checks++; if (n_both != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", n_both); end
        checks++; if (n_long != 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", n_long); end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_glitch();
        test_range();
        test_random();
        test_timeout();
        test_release_high();
        test_reset_mid_pulse();
        test_strobe_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
